// File: rtl/csr_regfile_if.sv
// Bus bundle between the WB stage and the CSR register file.
// The master side is the pipeline. The slave side is csr_regfile.
interface csr_regfile_if;
    logic        csr_valid;
    logic [7:0]  csr_op;
    logic [13:0] csr_num;
    logic [31:0] csr_wdata;
    logic [31:0] csr_wmask;
    logic [31:0] csr_rvalue;
    logic        ex_valid;
    logic [5:0]  ex_ecode;
    logic [8:0]  ex_esubcode;
    logic [31:0] ex_pc;
    logic        ertn_valid;
    logic [7:0]  hw_int_in;
    logic        ipi_in;
    logic        has_int;
    logic [31:0] ex_entry;
    logic [31:0] ertn_entry;

    modport master (
        output csr_valid, csr_op, csr_num, csr_wdata, csr_wmask,
        output ex_valid, ex_ecode, ex_esubcode, ex_pc, ertn_valid,
        output hw_int_in, ipi_in,
        input  csr_rvalue, has_int, ex_entry, ertn_entry
    );

    modport slave (
        input  csr_valid, csr_op, csr_num, csr_wdata, csr_wmask,
        input  ex_valid, ex_ecode, ex_esubcode, ex_pc, ertn_valid,
        input  hw_int_in, ipi_in,
        output csr_rvalue, has_int, ex_entry, ertn_entry
    );
endinterface

// File: rtl/csr_regfile.sv
// LoongArch CSR file: csrrd/csrwr/csrxchg at WB, exception/ERTN state, stable timer and interrupt request.
// Same-edge priority is reset > exception > ERTN > software write.
module csr_regfile #(
    parameter logic [31:0] TID_INIT   = 32'h0,
    parameter int unsigned TVAL_W     = 32,
    parameter logic [7:0]  OP_CSRRD   = 8'h01,
    parameter logic [7:0]  OP_CSRWR   = 8'h02,
    parameter logic [7:0]  OP_CSRXCHG = 8'h03
) (
    input  logic          clk,
    input  logic          reset,
    csr_regfile_if.slave  bus
);
    localparam logic [13:0] CSR_CRMD   = 14'h000;
    localparam logic [13:0] CSR_PRMD   = 14'h001;
    localparam logic [13:0] CSR_ECFG   = 14'h004;
    localparam logic [13:0] CSR_ESTAT  = 14'h005;
    localparam logic [13:0] CSR_ERA    = 14'h006;
    localparam logic [13:0] CSR_EENTRY = 14'h00C;
    localparam logic [13:0] CSR_SAVE0  = 14'h030;
    localparam logic [13:0] CSR_SAVE1  = 14'h031;
    localparam logic [13:0] CSR_SAVE2  = 14'h032;
    localparam logic [13:0] CSR_SAVE3  = 14'h033;
    localparam logic [13:0] CSR_TID    = 14'h040;
    localparam logic [13:0] CSR_TCFG   = 14'h041;
    localparam logic [13:0] CSR_TVAL   = 14'h042;
    localparam logic [13:0] CSR_TICLR  = 14'h044;

    // TCFG keeps only En, Periodic and InitVal; the reload value drops the two control bits.
    localparam logic [31:0]       TCFG_WMASK  = (TVAL_W >= 32) ? 32'hFFFF_FFFF
                                                               : ((32'h1 << TVAL_W) - 32'h1);
    localparam logic [TVAL_W-1:0] TVAL_ONE    = TVAL_W'(1);
    localparam logic [TVAL_W-1:0] RELOAD_MASK = ~(TVAL_W'(3));
    localparam logic [TVAL_W-1:0] TVAL_ZERO   = {TVAL_W{1'b0}};

    logic [1:0]        crmd_plv_r;
    logic              crmd_ie_r;
    logic              crmd_da_r;
    logic [1:0]        prmd_pplv_r;
    logic              prmd_pie_r;
    logic [12:0]       ecfg_lie_r;
    logic [1:0]        estat_is_sw_r;
    logic [7:0]        estat_is_hw_r;
    logic              estat_is_timer_r;
    logic              estat_is_ipi_r;
    logic [5:0]        estat_ecode_r;
    logic [8:0]        estat_esubcode_r;
    logic [31:0]       era_r;
    logic [25:0]       eentry_r;
    logic [31:0]       save_r [4];
    logic [31:0]       tid_r;
    logic [31:0]       tcfg_r;
    logic [TVAL_W-1:0] tval_r;

    logic [31:0]       estat_s;
    logic [31:0]       rvalue_s;
    logic [31:0]       mask_s;
    logic [31:0]       merged_s;
    logic              sw_we_s;
    logic              crmd_we_s;
    logic              prmd_we_s;
    logic              ecfg_we_s;
    logic              estat_we_s;
    logic              era_we_s;
    logic              eentry_we_s;
    logic              save_we_s;
    logic              tid_we_s;
    logic              tcfg_we_s;
    logic              ticlr_clr_s;
    logic [TVAL_W-1:0] reload_s;
    logic [TVAL_W-1:0] tval_nxt_s;
    logic              timer_fire_s;

    assign estat_s = {1'b0, estat_esubcode_r, estat_ecode_r, 3'b000,
                      estat_is_ipi_r, estat_is_timer_r, 1'b0, estat_is_hw_r, estat_is_sw_r};

    // Combinational read port; unimplemented numbers and TICLR read as zero.
    always_comb begin
        rvalue_s = 32'h0;
        case (bus.csr_num)
            CSR_CRMD:   rvalue_s = {28'h0, crmd_da_r, crmd_ie_r, crmd_plv_r};
            CSR_PRMD:   rvalue_s = {29'h0, prmd_pie_r, prmd_pplv_r};
            CSR_ECFG:   rvalue_s = {19'h0, ecfg_lie_r};
            CSR_ESTAT:  rvalue_s = estat_s;
            CSR_ERA:    rvalue_s = era_r;
            CSR_EENTRY: rvalue_s = {eentry_r, 6'h00};
            CSR_SAVE0:  rvalue_s = save_r[0];
            CSR_SAVE1:  rvalue_s = save_r[1];
            CSR_SAVE2:  rvalue_s = save_r[2];
            CSR_SAVE3:  rvalue_s = save_r[3];
            CSR_TID:    rvalue_s = tid_r;
            CSR_TCFG:   rvalue_s = tcfg_r;
            CSR_TVAL:   rvalue_s = 32'(tval_r);
            CSR_TICLR:  rvalue_s = 32'h0;
            default:    rvalue_s = 32'h0;
        endcase
    end

    assign bus.csr_rvalue = rvalue_s;
    assign bus.has_int    = crmd_ie_r & (|({estat_is_ipi_r, estat_is_timer_r, 1'b0,
                                            estat_is_hw_r, estat_is_sw_r} & ecfg_lie_r));
    assign bus.ex_entry   = {eentry_r, 6'h00};
    assign bus.ertn_entry = era_r;

    // Software write decode; exception or ERTN in the same cycle suppresses it.
    always_comb begin
        mask_s      = (bus.csr_op == OP_CSRXCHG) ? bus.csr_wmask : 32'hFFFF_FFFF;
        merged_s    = (rvalue_s & ~mask_s) | (bus.csr_wdata & mask_s);
        sw_we_s     = bus.csr_valid && ((bus.csr_op == OP_CSRWR) || (bus.csr_op == OP_CSRXCHG))
                      && !bus.ex_valid && !bus.ertn_valid;
        crmd_we_s   = sw_we_s && (bus.csr_num == CSR_CRMD);
        prmd_we_s   = sw_we_s && (bus.csr_num == CSR_PRMD);
        ecfg_we_s   = sw_we_s && (bus.csr_num == CSR_ECFG);
        estat_we_s  = sw_we_s && (bus.csr_num == CSR_ESTAT);
        era_we_s    = sw_we_s && (bus.csr_num == CSR_ERA);
        eentry_we_s = sw_we_s && (bus.csr_num == CSR_EENTRY);
        save_we_s   = sw_we_s && (bus.csr_num[13:2] == CSR_SAVE0[13:2]);
        tid_we_s    = sw_we_s && (bus.csr_num == CSR_TID);
        tcfg_we_s   = sw_we_s && (bus.csr_num == CSR_TCFG);
        ticlr_clr_s = sw_we_s && (bus.csr_num == CSR_TICLR) && merged_s[0];
    end

    // Timer next state: a TCFG write overrides counting on its own edge.
    always_comb begin
        reload_s     = tcfg_r[TVAL_W-1:0] & RELOAD_MASK;
        tval_nxt_s   = tval_r;
        timer_fire_s = 1'b0;
        if (tcfg_we_s) begin
            if (merged_s[0]) begin
                tval_nxt_s = merged_s[TVAL_W-1:0] & RELOAD_MASK;
            end else begin
                tval_nxt_s = tval_r;
            end
        end else if (tcfg_r[0] && (tval_r != TVAL_ZERO)) begin
            if (tval_r == TVAL_ONE) begin
                timer_fire_s = 1'b1;
                tval_nxt_s   = tcfg_r[1] ? reload_s : TVAL_ZERO;
            end else begin
                tval_nxt_s   = tval_r - TVAL_ONE;
            end
        end else begin
            tval_nxt_s = tval_r;
        end
    end

    // CRMD/PRMD: exception entry saves mode, ERTN restores it.
    always_ff @(posedge clk) begin
        if (reset) begin
            crmd_plv_r  <= 2'b00;
            crmd_ie_r   <= 1'b0;
            crmd_da_r   <= 1'b1;
            prmd_pplv_r <= 2'b00;
            prmd_pie_r  <= 1'b0;
        end else if (bus.ex_valid) begin
            prmd_pplv_r <= crmd_plv_r;
            prmd_pie_r  <= crmd_ie_r;
            crmd_plv_r  <= 2'b00;
            crmd_ie_r   <= 1'b0;
        end else if (bus.ertn_valid) begin
            crmd_plv_r  <= prmd_pplv_r;
            crmd_ie_r   <= prmd_pie_r;
        end else begin
            if (crmd_we_s) begin
                crmd_plv_r <= merged_s[1:0];
                crmd_ie_r  <= merged_s[2];
                crmd_da_r  <= merged_s[3];
            end
            if (prmd_we_s) begin
                prmd_pplv_r <= merged_s[1:0];
                prmd_pie_r  <= merged_s[2];
            end
        end
    end

    // ESTAT: level interrupts sampled every cycle, timer flag set beats TICLR clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            estat_is_sw_r    <= 2'b00;
            estat_is_hw_r    <= 8'h00;
            estat_is_timer_r <= 1'b0;
            estat_is_ipi_r   <= 1'b0;
            estat_ecode_r    <= 6'h00;
            estat_esubcode_r <= 9'h000;
        end else begin
            estat_is_hw_r  <= bus.hw_int_in;
            estat_is_ipi_r <= bus.ipi_in;
            if (timer_fire_s) begin
                estat_is_timer_r <= 1'b1;
            end else if (ticlr_clr_s) begin
                estat_is_timer_r <= 1'b0;
            end
            if (estat_we_s) begin
                estat_is_sw_r <= merged_s[1:0];
            end
            if (bus.ex_valid) begin
                estat_ecode_r    <= bus.ex_ecode;
                estat_esubcode_r <= bus.ex_esubcode;
            end
        end
    end

    // ERA captures the faulting PC ahead of any software write.
    always_ff @(posedge clk) begin
        if (reset) begin
            era_r <= 32'h0;
        end else if (bus.ex_valid) begin
            era_r <= bus.ex_pc;
        end else if (era_we_s) begin
            era_r <= merged_s;
        end
    end

    // Plain software-only registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            ecfg_lie_r <= 13'h0000;
            eentry_r   <= 26'h0;
            tid_r      <= TID_INIT;
            for (int i = 0; i < 4; i++) begin
                save_r[i] <= 32'h0;
            end
        end else begin
            if (ecfg_we_s) begin
                ecfg_lie_r <= merged_s[12:0];
            end
            if (eentry_we_s) begin
                eentry_r <= merged_s[31:6];
            end
            if (tid_we_s) begin
                tid_r <= merged_s;
            end
            if (save_we_s) begin
                save_r[bus.csr_num[1:0]] <= merged_s;
            end
        end
    end

    // Timer configuration and counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            tcfg_r <= 32'h0;
            tval_r <= TVAL_ZERO;
        end else begin
            if (tcfg_we_s) begin
                tcfg_r <= merged_s & TCFG_WMASK;
            end
            tval_r <= tval_nxt_s;
        end
    end
endmodule
